// File: rtl/mac_dataflow_pkg.sv
// Shared types for the multiply / dot-product stream engine: job FSM states and the
// per-job configuration snapshot taken when a dot-product job starts.
package mac_dataflow_pkg;

    localparam int MAC_DATA_W  = 32;
    localparam int MAC_CNT_LEN = 4096;
    localparam int MAC_SH_W    = $clog2(2 * MAC_DATA_W);
    localparam int MAC_LEN_W   = $clog2(MAC_CNT_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } mac_state_t;

    typedef struct packed {
        logic                 simple_mul;
        logic [MAC_SH_W-1:0]  shift;
        logic [MAC_LEN_W-1:0] len;
        logic                 round;
        logic                 sat;
    } mac_ctrl_t;

endpackage

// File: rtl/mac_dataflow_checker.sv
// Protocol checker for the result and joined operand streams of mac_dataflow.
module mac_dataflow_checker #(
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    input logic              a_valid,
    input logic              a_ready,
    input logic              b_valid,
    input logic              b_ready,
    input logic              d_valid,
    input logic              d_ready,
    input logic [DATA_W-1:0] d_data
);
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (d_valid && !d_ready) |=> (d_valid && $stable(d_data)))
        else $error("d stream dropped or changed before acceptance");

    a_ab_joined: assert property (@(posedge clk) disable iff (rst)
        ((a_valid && a_ready) == (b_valid && b_ready)))
        else $error("a and b handshakes diverged");

endmodule

// File: rtl/mac_dataflow_requant.sv
// Combinational requantiser: optional round-to-nearest, arithmetic right shift, then either
// saturation to the signed DATA_W range or plain truncation to the low DATA_W bits.
module mac_dataflow_requant #(
    parameter int IN_W   = 77,
    parameter int DATA_W = 32,
    parameter int SH_W   = 6
) (
    input  logic signed [IN_W-1:0]   v_i,
    input  logic        [SH_W-1:0]   shift_i,
    input  logic                     round_i,
    input  logic                     sat_i,
    output logic        [DATA_W-1:0] d_o,
    output logic                     clip_o
);
    // One guard bit so the rounding increment can never wrap the input.
    localparam int XW = IN_W + 1;
    localparam logic signed [XW-1:0] MAX_C = {{(XW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_C = {{(XW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [XW-1:0] rnd_s;
    logic signed [XW-1:0] x_s;
    logic signed [XW-1:0] y_s;

    // Round, shift and clip.
    always_comb begin
        rnd_s = '0;
        if (round_i && (shift_i != '0)) begin
            rnd_s = {{(XW-1){1'b0}}, 1'b1} << (shift_i - {{(SH_W-1){1'b0}}, 1'b1});
        end else begin
            rnd_s = '0;
        end
        x_s = XW'(v_i) + rnd_s;
        y_s = x_s >>> shift_i;
        if (sat_i && (y_s > MAX_C)) begin
            d_o    = {1'b0, {(DATA_W-1){1'b1}}};
            clip_o = 1'b1;
        end else if (sat_i && (y_s < MIN_C)) begin
            d_o    = {1'b1, {(DATA_W-1){1'b0}}};
            clip_o = 1'b1;
        end else begin
            d_o    = y_s[DATA_W-1:0];
            clip_o = 1'b0;
        end
    end

endmodule

// File: rtl/mac_dataflow.sv
// Multiply / dot-product stream engine: joined a/b operands, optional c bias, one requantised
// d result per simple pair or per dot-product job.
module mac_dataflow
    import mac_dataflow_pkg::*;
#(
    parameter int DATA_W  = MAC_DATA_W,
    parameter int MAX_LEN = MAC_CNT_LEN
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic                           a_TVALID,
    output logic                           a_TREADY,
    input  logic [DATA_W-1:0]              a_TDATA,
    input  logic                           b_TVALID,
    output logic                           b_TREADY,
    input  logic [DATA_W-1:0]              b_TDATA,
    input  logic                           c_TVALID,
    output logic                           c_TREADY,
    input  logic [DATA_W-1:0]              c_TDATA,
    output logic                           d_TVALID,
    input  logic                           d_TREADY,
    output logic [DATA_W-1:0]              d_TDATA,
    input  logic                           reg_simple_mul,
    input  logic [$clog2(2*DATA_W)-1:0]    reg_shift,
    input  logic [$clog2(MAX_LEN):0]       reg_len,
    input  logic                           reg_round,
    input  logic                           reg_sat,
    output logic                           busy_o,
    output logic                           sat_o
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + $clog2(MAX_LEN) + 1;
    localparam int SH_W   = $clog2(PROD_W);
    localparam int LEN_W  = $clog2(MAX_LEN) + 1;

    mac_state_t               state_q, state_d;
    mac_ctrl_t                ctrl_q, ctrl_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic signed [PROD_W-1:0] r_mult_q, r_mult_d;
    logic                     r_mult_valid_q, r_mult_valid_d;

    logic                     idle_s, accept_s, pair_hs_s, c_hs_s, d_valid_s, d_hs_s;
    logic [LEN_W-1:0]         len_clamp_s, job_len_s;
    logic [SH_W-1:0]          cur_shift_s;
    logic                     cur_round_s, cur_sat_s, rq_clip_s;
    logic signed [ACC_W-1:0]  rq_in_s;
    logic [DATA_W-1:0]        rq_d_s;

    // Handshake, output and requantiser-input decode.
    always_comb begin
        idle_s = (state_q == IDLE);
        case (state_q)
            IDLE:    accept_s = reg_simple_mul & (d_TREADY | ~r_mult_valid_q);
            ACCUM:   accept_s = 1'b1;
            default: accept_s = 1'b0;
        endcase
        accept_s    = accept_s & ~ap_rst;
        a_TREADY    = b_TVALID & accept_s;
        b_TREADY    = a_TVALID & accept_s;
        pair_hs_s   = a_TVALID & b_TVALID & accept_s;
        c_TREADY    = ~ap_rst & idle_s & ~reg_simple_mul & ~r_mult_valid_q;
        c_hs_s      = c_TVALID & c_TREADY;
        d_valid_s   = (idle_s & r_mult_valid_q) | (state_q == OUT);
        d_hs_s      = d_valid_s & d_TREADY;
        len_clamp_s = (reg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : reg_len;
        job_len_s   = LEN_W'(ctrl_q.len);
        // Simple mode follows the live registers; a running job uses its snapshot.
        if (idle_s) begin
            cur_shift_s = reg_shift;
            cur_round_s = reg_round;
            cur_sat_s   = reg_sat;
        end else begin
            cur_shift_s = SH_W'(ctrl_q.shift);
            cur_round_s = ctrl_q.round;
            cur_sat_s   = ctrl_q.sat;
        end
        rq_in_s  = (state_q == OUT) ? acc_q : ACC_W'(r_mult_q);
        busy_o   = ~idle_s;
        d_TVALID = d_valid_s;
        d_TDATA  = d_valid_s ? rq_d_s : '0;
        sat_o    = d_valid_s & rq_clip_s;
    end

    mac_dataflow_requant #(
        .IN_W   (ACC_W),
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_requant (
        .v_i     (rq_in_s),
        .shift_i (cur_shift_s),
        .round_i (cur_round_s),
        .sat_i   (cur_sat_s),
        .d_o     (rq_d_s),
        .clip_o  (rq_clip_s)
    );

    // Next-state logic for the product register and the job FSM.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        r_mult_d = r_mult_q;
        if (pair_hs_s) begin
            r_mult_d       = PROD_W'($signed(a_TDATA)) * PROD_W'($signed(b_TDATA));
            r_mult_valid_d = 1'b1;
        end else if (idle_s) begin
            r_mult_valid_d = r_mult_valid_q & ~d_TREADY;
        end else begin
            r_mult_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (c_hs_s) begin
                    ctrl_d.simple_mul = reg_simple_mul;
                    ctrl_d.shift      = MAC_SH_W'(reg_shift);
                    ctrl_d.len        = MAC_LEN_W'(len_clamp_s);
                    ctrl_d.round      = reg_round;
                    ctrl_d.sat        = reg_sat;
                    acc_d             = ACC_W'($signed(c_TDATA)) <<< reg_shift;
                    cnt_d             = '0;
                    state_d           = (len_clamp_s != '0) ? ACCUM : OUT;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (r_mult_valid_q) begin
                    acc_d = acc_q + ACC_W'(r_mult_q);
                end else begin
                    acc_d = acc_q;
                end
                if (pair_hs_s) begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q == job_len_s - LEN_W'(1)) ? DRAIN : ACCUM;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                if (r_mult_valid_q) begin
                    acc_d = acc_q + ACC_W'(r_mult_q);
                end else begin
                    acc_d = acc_q;
                end
                state_d = OUT;
            end
            OUT: begin
                if (d_hs_s) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q        <= IDLE;
            ctrl_q         <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            r_mult_q       <= '0;
            r_mult_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ctrl_q         <= ctrl_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            r_mult_q       <= r_mult_d;
            r_mult_valid_q <= r_mult_valid_d;
        end
    end

endmodule

// File: tb/tb_mac_dataflow.sv
// Directed scoreboard bench for mac_dataflow: stimulus pushes expected d words, a negedge
// monitor pops and compares on every d handshake.
module tb_mac_dataflow;
    localparam int DATA_W = 32;
    localparam int SH_W   = 6;
    localparam int LEN_W  = 13;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              a_TVALID, a_TREADY, b_TVALID, b_TREADY, c_TVALID, c_TREADY;
    logic              d_TVALID, d_TREADY;
    logic [DATA_W-1:0] a_TDATA, b_TDATA, c_TDATA, d_TDATA;
    logic              reg_simple_mul, reg_round, reg_sat, busy_o, sat_o;
    logic [SH_W-1:0]   reg_shift;
    logic [LEN_W-1:0]  reg_len;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   out_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 ap_clk = ~ap_clk;

    mac_dataflow #(.DATA_W(DATA_W), .MAX_LEN(4096)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .a_TVALID(a_TVALID), .a_TREADY(a_TREADY), .a_TDATA(a_TDATA),
        .b_TVALID(b_TVALID), .b_TREADY(b_TREADY), .b_TDATA(b_TDATA),
        .c_TVALID(c_TVALID), .c_TREADY(c_TREADY), .c_TDATA(c_TDATA),
        .d_TVALID(d_TVALID), .d_TREADY(d_TREADY), .d_TDATA(d_TDATA),
        .reg_simple_mul(reg_simple_mul), .reg_shift(reg_shift), .reg_len(reg_len),
        .reg_round(reg_round), .reg_sat(reg_sat), .busy_o(busy_o), .sat_o(sat_o)
    );

    mac_dataflow_checker #(.DATA_W(DATA_W)) u_chk (
        .clk(ap_clk), .rst(ap_rst),
        .a_valid(a_TVALID), .a_ready(a_TREADY), .b_valid(b_TVALID), .b_ready(b_TREADY),
        .d_valid(d_TVALID), .d_ready(d_TREADY), .d_data(d_TDATA)
    );

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every d handshake is checked against the head of the scoreboard.
    always @(negedge ap_clk) begin
        if (!ap_rst && d_TVALID && d_TREADY) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_d: got %0h, no result expected", d_TDATA);
            end else begin
                mon_e = exp_q.pop_front();
                chk("d_data", d_TDATA, mon_e.d);
                chk("sat_o", sat_o, mon_e.sat);
            end
        end
    end

    task automatic expect_d(input logic [DATA_W-1:0] d, input logic sat);
        exp_t e;
        e.d   = d;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    task automatic cfg(input logic simple, input int shift, input int len,
                       input logic rnd, input logic sat);
        reg_simple_mul = simple;
        reg_shift      = SH_W'(shift);
        reg_len        = LEN_W'(len);
        reg_round      = rnd;
        reg_sat        = sat;
    endtask

    task automatic send_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bit ok = 1'b0;
        a_TDATA  = a;
        b_TDATA  = b;
        a_TVALID = 1'b1;
        b_TVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            if (a_TREADY && b_TREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL pair_timeout: got no a/b ready, expected ready within 50 cycles");
        end
        @(posedge ap_clk);
        #1;
        a_TVALID = 1'b0;
        b_TVALID = 1'b0;
    endtask

    task automatic send_c(input logic [DATA_W-1:0] c);
        bit ok = 1'b0;
        c_TDATA  = c;
        c_TVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            if (c_TREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL c_timeout: got no c ready, expected ready within 50 cycles");
        end
        @(posedge ap_clk);
        #1;
        c_TVALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge ap_clk);
            #1;
            if (exp_q.size() == 0 && !d_TVALID && !busy_o) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, done, 1);
    endtask

    int t1_a[8] = '{1, -2, 100, 7, -8, 0, 65536, -1};
    int t1_b[8] = '{9, 4, -3, 7, -8, 12345, 65536, -1};
    int t1_d[8] = '{9, -8, -300, 49, 64, 0, 0, 1};
    // c, a0, a1, b0, b1, round, expected d
    int t3[4][7] = '{'{1, 16, 16, 1, 1, 1, 3}, '{1, 16, 16, 1, 1, 0, 3},
                     '{0, 8, 0, 1, 0, 1, 1},   '{0, 8, 0, 1, 0, 0, 0}};

    initial begin
        int base;
        logic [DATA_W-1:0] maxpos;
        maxpos = 32'h7FFF_FFFF;
        ap_rst = 1'b1;
        a_TVALID = 1'b0; b_TVALID = 1'b0; c_TVALID = 1'b0; d_TREADY = 1'b0;
        a_TDATA = '0; b_TDATA = '0; c_TDATA = '0;
        cfg(1'b1, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge ap_clk);
        #1;
        // Reset: readies held low even with valid operands offered.
        a_TVALID = 1'b1; b_TVALID = 1'b1; c_TVALID = 1'b1; d_TREADY = 1'b1;
        #1;
        chk("rst_a_ready", a_TREADY, 0);
        chk("rst_b_ready", b_TREADY, 0);
        reg_simple_mul = 1'b0;
        #1;
        chk("rst_c_ready", c_TREADY, 0);
        chk("rst_d_valid", d_TVALID, 0);
        chk("rst_d_data", d_TDATA, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sat", sat_o, 0);
        a_TVALID = 1'b0; b_TVALID = 1'b0; c_TVALID = 1'b0;
        reg_simple_mul = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // 1: simple multiply, latency and back-to-back throughput
        expect_d(-32'sd21, 1'b0);
        send_pair(32'd3, -32'sd7);
        chk("t1_latency", d_TVALID, 1);
        wait_idle("t1_idle_a");
        base = out_cyc.size();
        for (int i = 0; i < 8; i++) expect_d(DATA_W'(t1_d[i]), 1'b0);
        for (int i = 0; i < 8; i++) send_pair(DATA_W'(t1_a[i]), DATA_W'(t1_b[i]));
        wait_idle("t1_idle_b");
        chk("t1_count", out_cyc.size() - base, 8);
        if (out_cyc.size() >= base + 8) chk("t1_no_bubble", out_cyc[base+7] - out_cyc[base], 7);

        // 2: dot product len 4
        cfg(1'b0, 0, 4, 1'b0, 1'b0);
        expect_d(32'd80, 1'b0);
        send_c(32'd10);
        chk("t2_busy_start", busy_o, 1);
        send_pair(32'd1, 32'd5);
        send_pair(32'd2, 32'd6);
        send_pair(32'd3, 32'd7);
        send_pair(32'd4, 32'd8);
        chk("t2_drain_no_valid", d_TVALID, 0);
        chk("t2_busy_drain", busy_o, 1);
        @(posedge ap_clk);
        #1;
        chk("t2_out_valid", d_TVALID, 1);
        wait_idle("t2_idle");

        // 3: shift and rounding
        for (int j = 0; j < 4; j++) begin
            cfg(1'b0, 4, 2, t3[j][5][0], 1'b1);
            expect_d(DATA_W'(t3[j][6]), 1'b0);
            send_c(DATA_W'(t3[j][0]));
            send_pair(DATA_W'(t3[j][1]), DATA_W'(t3[j][3]));
            send_pair(DATA_W'(t3[j][2]), DATA_W'(t3[j][4]));
            wait_idle("t3_idle");
        end

        // 4: saturation versus truncation
        cfg(1'b1, 0, 0, 1'b0, 1'b1);
        expect_d(maxpos, 1'b1);
        send_pair(maxpos, maxpos);
        wait_idle("t4_idle_sat");
        cfg(1'b1, 0, 0, 1'b0, 1'b0);
        expect_d(32'd1, 1'b0);
        send_pair(maxpos, maxpos);
        wait_idle("t4_idle_trunc");

        // 5: len 0 with backpressure, then a without b
        cfg(1'b0, 0, 0, 1'b0, 1'b0);
        d_TREADY = 1'b0;
        expect_d(-32'sd5, 1'b0);
        send_c(-32'sd5);
        chk("t5_latency", d_TVALID, 1);
        a_TVALID = 1'b1;
        b_TVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge ap_clk);
            #1;
            chk("t5_hold_valid", d_TVALID, 1);
            chk("t5_hold_data", d_TDATA, 32'hFFFF_FFFB);
            chk("t5_hold_a_ready", a_TREADY, 0);
        end
        a_TVALID = 1'b0;
        b_TVALID = 1'b0;
        d_TREADY = 1'b1;
        wait_idle("t5_idle");
        cfg(1'b1, 0, 0, 1'b0, 1'b0);
        a_TDATA  = 32'd9;
        a_TVALID = 1'b1;
        base = out_cyc.size();
        for (int i = 0; i < 5; i++) begin
            @(posedge ap_clk);
            #1;
            chk("t5_a_only_ready", a_TREADY, 0);
        end
        chk("t5_a_only_no_d", out_cyc.size() - base, 0);
        a_TVALID = 1'b0;
        expect_d(32'd35, 1'b0);
        send_pair(32'd5, 32'd7);
        wait_idle("t5_idle_b");

        // 6: reset mid-job, then a fresh job
        cfg(1'b0, 0, 4, 1'b0, 1'b0);
        send_c(32'd0);
        send_pair(32'd1, 32'd1);
        send_pair(32'd1, 32'd1);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        chk("t6_busy_after_rst", busy_o, 0);
        chk("t6_valid_after_rst", d_TVALID, 0);
        cfg(1'b0, 0, 1, 1'b0, 1'b0);
        expect_d(32'd6, 1'b0);
        send_c(32'd0);
        send_pair(32'd2, 32'd3);
        wait_idle("t6_idle");

        chk("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
